// File: rtl/serial_add_ctrl.sv
// Round-robin controller sharing one external bit-serial adder between two parallel-operand requesters.
// Optional signed-overflow output enabled by defining SERIAL_ADD_CTRL_OVF_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             add_x,
    output logic             add_y,
    output logic             add_clr,
    input  logic             add_sum,
    input  logic             add_carry,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             done,
    output logic             done_id
`ifdef SERIAL_ADD_CTRL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_CAP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_idx;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-2:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_cur_id;
    logic             r_last_id;
    logic             r_done_id;
    logic             w_any;
    logic             w_pick1;
    logic             w_last_bit;

    assign w_any      = req0 | req1;
    // On a tie the requester that was not served last wins.
    assign w_pick1    = req1 & (~req0 | ~r_last_id);
    assign w_last_bit = (r_cnt == CW'(WIDTH - 1));
    assign w_idx      = r_cnt - CW'(1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_CLR;
            S_CLR:   w_next = S_RUN;
            S_RUN:   if (w_last_bit) w_next = S_CAP;
            S_CAP:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_cout    <= 1'b0;
            r_cur_id  <= 1'b0;
            r_last_id <= 1'b1;
            r_done_id <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_cur_id  <= w_pick1;
                        r_last_id <= w_pick1;
                        r_opa     <= w_pick1 ? a1 : a0;
                        r_opb     <= w_pick1 ? b1 : b0;
                    end
                end
                S_CLR: r_cnt <= '0;
                S_RUN: begin
                    // add_sum lags the presented bits by one cycle.
                    if (r_cnt != '0) r_acc[w_idx] <= add_sum;
                    if (!w_last_bit) r_cnt <= r_cnt + CW'(1);
                end
                S_CAP: begin
                    r_result  <= {add_sum, r_acc};
                    r_cout    <= add_carry;
                    r_done_id <= r_cur_id;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADD_CTRL_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_CAP) begin
            r_ovf <= (r_opa[WIDTH-1] == r_opb[WIDTH-1]) && (add_sum != r_opa[WIDTH-1]);
        end
    end

    assign ovf = r_ovf;
`endif

    assign gnt0    = (r_state == S_CLR) && !r_cur_id;
    assign gnt1    = (r_state == S_CLR) &&  r_cur_id;
    assign add_clr = (r_state == S_IDLE) || (r_state == S_CLR);
    assign add_x   = (r_state == S_RUN) ? r_opa[r_cnt] : 1'b0;
    assign add_y   = (r_state == S_RUN) ? r_opb[r_cnt] : 1'b0;
    assign done    = (r_state == S_DONE);
    assign done_id = r_done_id;
    assign result  = r_result;
    assign cout    = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl with a behavioural registered serial adder.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, add_x, add_y, add_clr;
    logic         add_sum, add_carry;
    logic [W-1:0] result;
    logic         cout, done, done_id;
`ifdef SERIAL_ADD_CTRL_OVF_EN
    logic         ovf;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .add_x(add_x), .add_y(add_y), .add_clr(add_clr),
        .add_sum(add_sum), .add_carry(add_carry),
        .result(result), .cout(cout), .done(done), .done_id(done_id)
`ifdef SERIAL_ADD_CTRL_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    // Serial adder: registered sum/carry, synchronous clear, no reset.
    always @(posedge clk) begin
        logic [1:0] s;
        s = 2'(add_x) + 2'(add_y) + 2'(add_carry);
        if (add_clr) begin
            add_sum   <= 1'b0;
            add_carry <= 1'b0;
        end else begin
            add_sum   <= s[0];
            add_carry <= s[1];
        end
    end

    typedef struct packed {
        logic         id;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] s;
        s    = {1'b0, a} + {1'b0, b};
        e.id  = id;
        e.res = s[W-1:0];
        e.co  = s[W];
        e.ov  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                chk("unexp_done", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("cout", cout, e.co);
                chk("done_id", done_id, e.id);
`ifdef SERIAL_ADD_CTRL_OVF_EN
                chk("ovf", ovf, e.ov);
`endif
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one request and check grant/done latency; called at a negedge.
    task automatic do_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        int n, g_at, d_at;
        push_exp(id, a, b);
        if (id) begin a1 = a; b1 = b; req1 = 1'b1; end
        else    begin a0 = a; b0 = b; req0 = 1'b1; end
        n = 0; g_at = -1; d_at = -1;
        while (d_at < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if ((gnt0 || gnt1) && g_at < 0) begin
                g_at = n;
                chk("gnt_sel", {gnt1, gnt0}, id ? 2'b10 : 2'b01);
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (done) d_at = n;
        end
        chk("gnt_lat", g_at, 1);
        chk("done_lat", d_at, W + 3);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    initial begin
        int n, gcount, last_g, dcount;

        repeat (2) @(negedge clk);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_addxy", {add_x, add_y}, 0);
        chk("rst_clr", add_clr, 1);
        chk("rst_result", result, 0);
        chk("rst_cout_done", {cout, done, done_id}, 0);
`ifdef SERIAL_ADD_CTRL_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b0, 8'h5A, 8'h3C);
        do_req(1'b1, 8'hFF, 8'h01);
`ifdef SERIAL_ADD_CTRL_OVF_EN
        do_req(1'b0, 8'h7F, 8'h01);
        do_req(1'b1, 8'h80, 8'h80);
`endif
        for (int i = 0; i < 6; i++) begin
            do_req(1'(i), 8'($urandom), 8'($urandom));
        end
        wait_drain();

        // Tie: both held from reset, expect 0,1,0,1 spaced W+4 apart.
        rst = 1'b1;
        a0 = 8'h11; b0 = 8'h22; a1 = 8'hF0; b1 = 8'h20;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_exp(1'b0, 8'h11, 8'h22);
            else            push_exp(1'b1, 8'hF0, 8'h20);
        end
        @(negedge clk);
        rst = 1'b0;
        n = 0; gcount = 0; last_g = 0;
        while (gcount < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (gnt0 || gnt1) begin
                chk("tie_order", gnt1, gcount % 2);
                if (gcount > 0) chk("tie_gap", n - last_g, W + 4);
                last_g = n;
                gcount++;
                if (gcount == 4) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        chk("tie_grants", gcount, 4);
        wait_drain();

        // Reset at cnt=4 of an all-carry add, then a clean add.
        a0 = 8'hFF; b0 = 8'hFF; req0 = 1'b1;
        n = 0;
        while (!gnt0 && n < 20) begin @(negedge clk); n++; end
        chk("mr_gnt", gnt0, 1);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr_clr", add_clr, 1);
        chk("mr_addxy", {add_x, add_y}, 0);
        chk("mr_outs", {gnt1, gnt0, done, done_id, cout}, 0);
        chk("mr_result", result, 0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (W + 6) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("mr_no_done", dcount, 0);
        do_req(1'b0, 8'h10, 8'h20);
        wait_drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
